// File: rtl/cr_kme_stitcher_ob.sv
// KME stitcher output stage: pulls from the stitcher into a 2-entry skid buffer,
// presents words on valid/ready, and checks TLV framing and TLV length on the accepted stream.
package cr_kme_stitcher_ob_pkg;
  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tuser;
    logic        tlast;
  } axi4s_dp_bus_t;
endpackage

module cr_kme_stitcher_ob
  import cr_kme_stitcher_ob_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  axi4s_dp_bus_t stitcher_out,
  input  logic          stitcher_empty,
  output logic          stitcher_rd,
  output axi4s_dp_bus_t kme_ob_out,
  output logic          kme_ob_valid,
  input  logic          kme_ob_ready,
  output logic          tlv_len_vld,
  output logic [LEN_W-1:0] tlv_len,
  output logic          err_sot_in_tlv,
  output logic          err_orphan,
  output logic          err_tlast
);

  logic [1:0]       r_cnt;
  axi4s_dp_bus_t    r_buf0;
  axi4s_dp_bus_t    r_buf1;
  logic             r_in_tlv;
  logic [LEN_W-1:0] r_len;
  logic             w_push;
  logic             w_pop;
  logic             w_is_sot;
  logic             w_is_eot;
  logic [LEN_W-1:0] w_len_inc;

  // rst_n gating keeps the stitcher untouched while reset is held
  assign stitcher_rd  = rst_n & ~stitcher_empty & (r_cnt != 2'd2);
  assign w_push       = stitcher_rd;
  assign kme_ob_valid = (r_cnt != 2'd0);
  assign w_pop        = kme_ob_valid & kme_ob_ready;
  assign kme_ob_out   = r_buf0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= stitcher_out;
          else               r_buf1 <= stitcher_out;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // push implies cnt != 2 and pop implies cnt != 0, so exactly one entry is held
          r_buf0 <= stitcher_out;
        end
        default: ;
      endcase
    end
  end

  assign w_is_sot  = (r_buf0.tuser == 8'd1);
  assign w_is_eot  = (r_buf0.tuser == 8'd2);
  assign w_len_inc = (&r_len) ? r_len : r_len + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_tlv       <= 1'b0;
      r_len          <= '0;
      tlv_len_vld    <= 1'b0;
      tlv_len        <= '0;
      err_sot_in_tlv <= 1'b0;
      err_orphan     <= 1'b0;
      err_tlast      <= 1'b0;
    end else begin
      tlv_len_vld    <= 1'b0;
      err_sot_in_tlv <= 1'b0;
      err_orphan     <= 1'b0;
      err_tlast      <= 1'b0;
      if (w_pop) begin
        err_tlast <= r_buf0.tlast & ~w_is_eot;
        if (w_is_sot) begin
          err_sot_in_tlv <= r_in_tlv;
          r_in_tlv       <= 1'b1;
          r_len          <= LEN_W'(1);
        end else if (!r_in_tlv) begin
          err_orphan <= 1'b1;
        end else begin
          r_len <= w_len_inc;
          if (w_is_eot) begin
            tlv_len_vld <= 1'b1;
            tlv_len     <= w_len_inc;
            r_in_tlv    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_kme_stitcher_ob.sv
// Directed bench for cr_kme_stitcher_ob: queue-based stitcher source, in-order scoreboard,
// pulse counters checked against hand-computed TLV lengths and error counts.
module tb_cr_kme_stitcher_ob;
  import cr_kme_stitcher_ob_pkg::*;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  axi4s_dp_bus_t    stitcher_out;
  logic             stitcher_empty;
  logic             stitcher_rd;
  axi4s_dp_bus_t    kme_ob_out;
  logic             kme_ob_valid;
  logic             kme_ob_ready;
  logic             tlv_len_vld;
  logic [LEN_W-1:0] tlv_len;
  logic             err_sot_in_tlv;
  logic             err_orphan;
  logic             err_tlast;

  cr_kme_stitcher_ob #(.LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stitcher_out   (stitcher_out),
    .stitcher_empty (stitcher_empty),
    .stitcher_rd    (stitcher_rd),
    .kme_ob_out     (kme_ob_out),
    .kme_ob_valid   (kme_ob_valid),
    .kme_ob_ready   (kme_ob_ready),
    .tlv_len_vld    (tlv_len_vld),
    .tlv_len        (tlv_len),
    .err_sot_in_tlv (err_sot_in_tlv),
    .err_orphan     (err_orphan),
    .err_tlast      (err_tlast)
  );

  always #5 clk = ~clk;

  axi4s_dp_bus_t src_q[$];
  axi4s_dp_bus_t exp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_rd, n_acc, n_len, n_sot, n_orph, n_tl;
  int first_rd_cyc, first_vld_cyc;
  logic [LEN_W-1:0] last_len;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic axi4s_dp_bus_t mk(input logic [63:0] d, input logic [7:0] u, input logic l);
    axi4s_dp_bus_t w;
    w.tdata = d;
    w.tuser = u;
    w.tlast = l;
    return w;
  endfunction

  task automatic clr();
    n_rd = 0; n_acc = 0; n_len = 0; n_sot = 0; n_orph = 0; n_tl = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; last_len = '0;
  endtask

  // One cycle: observe registered pulses, drive inputs, then model the coming edge.
  task automatic step(input logic rdy);
    @(negedge clk);
    cyc++;
    if (tlv_len_vld) begin n_len++; last_len = tlv_len; end
    if (err_sot_in_tlv) n_sot++;
    if (err_orphan) n_orph++;
    if (err_tlast) n_tl++;
    kme_ob_ready   = rdy;
    stitcher_empty = (src_q.size() == 0);
    stitcher_out   = stitcher_empty ? '0 : src_q[0];
    #1;
    if (kme_ob_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (kme_ob_valid && kme_ob_ready) begin
      n_acc++;
      if (exp_q.size() == 0) chk("spurious_word", kme_ob_valid, 1'b0);
      else chk("data_order", kme_ob_out, exp_q.pop_front());
    end
    if (stitcher_rd) begin
      n_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      exp_q.push_back(src_q.pop_front());
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      step(1'b1);
      k++;
    end
    step(1'b1);
    step(1'b1);
    chk("drain_left", src_q.size() + exp_q.size(), 0);
  endtask

  task automatic chk_errs(input string tag, input int sot, input int orph, input int tl);
    chk({tag, "_sot"}, n_sot, sot);
    chk({tag, "_orph"}, n_orph, orph);
    chk({tag, "_tlast"}, n_tl, tl);
  endtask

  initial begin
    rst_n          = 1'b0;
    stitcher_empty = 1'b0;
    stitcher_out   = mk(64'h55, 8'd1, 1'b0);
    kme_ob_ready   = 1'b1;
    clr();
    #12;
    chk("rst_rd", stitcher_rd, 1'b0);
    chk("rst_vld", kme_ob_valid, 1'b0);
    chk("rst_out", kme_ob_out, '0);
    chk("rst_len_vld", tlv_len_vld, 1'b0);
    chk("rst_len", tlv_len, '0);
    chk("rst_errs", {err_sot_in_tlv, err_orphan, err_tlast}, 3'b000);
    stitcher_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // stream: SOT, data, data, EOT(tlast)
    clr();
    src_q.push_back(mk(64'hA0, 8'd1, 1'b0));
    src_q.push_back(mk(64'hA1, 8'd0, 1'b0));
    src_q.push_back(mk(64'hA2, 8'd0, 1'b0));
    src_q.push_back(mk(64'hA3, 8'd2, 1'b1));
    repeat (8) step(1'b1);
    chk("stream_acc", n_acc, 4);
    chk("stream_lat", first_vld_cyc, first_rd_cyc + 1);
    chk("stream_nlen", n_len, 1);
    chk("stream_len", last_len, 10'd4);
    chk_errs("stream", 0, 0, 0);

    // backpressure: ready low for 5 cycles
    clr();
    src_q.push_back(mk(64'hB0, 8'd1, 1'b0));
    for (int i = 1; i <= 4; i++) src_q.push_back(mk(64'hB0 + 64'(i), 8'd0, 1'b0));
    src_q.push_back(mk(64'hB5, 8'd2, 1'b1));
    repeat (5) step(1'b0);
    chk("bp_pops", n_rd, 2);
    chk("bp_buffered", exp_q.size(), 2);
    chk("bp_rd_low", stitcher_rd, 1'b0);
    chk("bp_vld", kme_ob_valid, 1'b1);
    drain(20);
    chk("bp_acc", n_acc, 6);
    chk("bp_len", last_len, 10'd6);
    chk_errs("bp", 0, 0, 0);

    // framing: SOT, data, SOT, EOT -> restart, length 2
    clr();
    src_q.push_back(mk(64'hC0, 8'd1, 1'b0));
    src_q.push_back(mk(64'hC1, 8'd0, 1'b0));
    src_q.push_back(mk(64'hC2, 8'd1, 1'b0));
    src_q.push_back(mk(64'hC3, 8'd2, 1'b1));
    drain(20);
    chk("frm_nlen", n_len, 1);
    chk("frm_len", last_len, 10'd2);
    chk_errs("frm", 1, 0, 0);

    // orphan data word carrying tlast: both pulses on one word
    clr();
    src_q.push_back(mk(64'hD0, 8'd0, 1'b1));
    drain(10);
    chk("orph_nlen", n_len, 0);
    chk_errs("orph", 0, 1, 1);

    // tlast on an in-TLV data word
    clr();
    src_q.push_back(mk(64'hE0, 8'd1, 1'b0));
    src_q.push_back(mk(64'hE1, 8'd0, 1'b1));
    src_q.push_back(mk(64'hE2, 8'd2, 1'b1));
    drain(10);
    chk("tl_len", last_len, 10'd3);
    chk_errs("tl", 0, 0, 1);

    // saturation: 1030-word TLV
    clr();
    src_q.push_back(mk(64'hF000, 8'd1, 1'b0));
    for (int i = 1; i <= 1028; i++) src_q.push_back(mk(64'hF000 + 64'(i), 8'd0, 1'b0));
    src_q.push_back(mk(64'hF405, 8'd2, 1'b1));
    drain(1100);
    chk("sat_acc", n_acc, 1030);
    chk("sat_len", last_len, 10'd1023);
    chk_errs("sat", 0, 0, 0);

    // mid-frame reset with SOT accepted and two words buffered
    clr();
    src_q.push_back(mk(64'h100, 8'd1, 1'b0));
    for (int i = 1; i <= 4; i++) src_q.push_back(mk(64'h100 + 64'(i), 8'd0, 1'b0));
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("mrst_buffered", exp_q.size(), 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", kme_ob_valid, 1'b0);
    chk("mrst_rd", stitcher_rd, 1'b0);
    src_q.delete();
    exp_q.delete();
    stitcher_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    src_q.push_back(mk(64'h200, 8'd1, 1'b0));
    src_q.push_back(mk(64'h201, 8'd0, 1'b0));
    src_q.push_back(mk(64'h202, 8'd2, 1'b1));
    drain(10);
    chk("mrst_nlen", n_len, 1);
    chk("mrst_len", last_len, 10'd3);
    chk_errs("mrst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
